// File: rtl/ieee_to_fp_11_23.sv
// ieee_to_fp_11_23: two-stage binary32 to wE=11/wF=23 encoder.
// S1 classifies and counts leading zeros, S2 builds the word.
module ieee_to_fp_11_23 #(
  parameter int width = 36,
  parameter int wE    = 11,
  parameter int wF    = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ieee,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width:0]   out_R
);

  typedef enum logic [2:0] {
    C_ZERO,
    C_SUB,
    C_NORM,
    C_INF,
    C_NAN
  } cls_t;

  logic          adv;
  logic          s1_valid;
  logic          s1_sign;
  logic [7:0]    s1_exp;
  logic [wF-1:0] s1_man;
  cls_t          s1_cls;
  logic [4:0]    s1_lz;
  logic          s2_valid;

  logic [7:0]    e;
  logic [wF-1:0] m;
  cls_t          cls;
  logic [4:0]    lz;

  logic [wE-1:0] sub_exp;
  logic [wF-1:0] sub_frac;
  logic [wE-1:0] nrm_exp;

  assign adv       = !s2_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = s2_valid;

  assign e = in_ieee[30:23];
  assign m = in_ieee[22:0];

  // Leading-zero count of the mantissa: highest set bit wins.
  always_comb begin
    lz = '0;
    for (int i = 0; i < 23; i++) begin
      if (m[i]) lz = 5'(22 - i);
    end
  end

  // Operand class from the raw exponent and mantissa.
  always_comb begin
    cls = C_NORM;
    unique case (1'b1)
      (e == 8'd0)   && (m == '0): cls = C_ZERO;
      (e == 8'd0)   && (m != '0): cls = C_SUB;
      (e == 8'hff)  && (m == '0): cls = C_INF;
      (e == 8'hff)  && (m != '0): cls = C_NAN;
      default:                    cls = C_NORM;
    endcase
  end

  // Rebias and normalise from the S1 fields.
  always_comb begin
    sub_exp  = 11'd896 - {6'd0, s1_lz};
    sub_frac = s1_man << (s1_lz + 5'd1);
    nrm_exp  = {3'd0, s1_exp} + 11'd896;
  end

  // S1: capture the operand with its class and lz.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_man   <= '0;
      s1_cls   <= C_ZERO;
      s1_lz    <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= in_ieee[31];
      s1_exp   <= e;
      s1_man   <= m;
      s1_cls   <= cls;
      s1_lz    <= lz;
    end
  end

  // S2: assemble the internal-format word; hold it while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_R    <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        unique case (s1_cls)
          C_ZERO:  out_R <= {2'b00, s1_sign, 11'd0, 23'd0};
          C_SUB:   out_R <= {2'b01, s1_sign, sub_exp, sub_frac};
          C_NORM:  out_R <= {2'b01, s1_sign, nrm_exp, s1_man};
          C_INF:   out_R <= {2'b10, s1_sign, 11'd0, 23'd0};
          C_NAN:   out_R <= {2'b11, s1_sign, 11'd0, 23'd0};
          default: out_R <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ieee_to_fp_11_23.sv
// tb_ieee_to_fp_11_23: scoreboard bench for the binary32 encoder.
// Expectations queued on accept, checked when the DUT emits.
module tb_ieee_to_fp_11_23;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ieee;
  logic        out_valid;
  logic        out_ready;
  logic [36:0] out_R;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit lat_chk = 1'b1;

  logic [36:0] sb_exp[$];
  int          sb_cyc[$];

  ieee_to_fp_11_23 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ieee   (in_ieee),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_R     (out_R)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [36:0] got,
                     input logic [36:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [36:0] model(input logic [31:0] x);
    logic        s;
    logic [7:0]  ex;
    logic [22:0] mn;
    logic [45:0] t;
    int          p;
    s  = x[31];
    ex = x[30:23];
    mn = x[22:0];
    if (ex == 8'd0 && mn == 23'd0) return {2'b00, s, 34'd0};
    if (ex == 8'd255)
      return (mn == 23'd0) ? {2'b10, s, 34'd0} : {2'b11, s, 34'd0};
    if (ex != 8'd0) return {2'b01, s, 11'(ex + 896), mn};
    p = 0;
    for (int i = 0; i < 23; i++) if (mn[i]) p = i;
    t = {23'd0, mn} << (23 - p);
    return {2'b01, s, 11'(874 + p), t[22:0]};
  endfunction

  // Monitor: a handshake is sampled mid-cycle and scored.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_exp.size() == 0) begin
        chk("extra_out", out_R, 37'h0);
        n_err++;
        $display("FAIL dup_out got %h exp none", out_R);
      end else begin
        chk("data", out_R, sb_exp.pop_front());
        if (lat_chk)
          chk("latency", 37'(cyc), 37'(sb_cyc[0] + 2));
        void'(sb_cyc.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] x);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_ieee  = x;
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        sb_exp.push_back(model(x));
        sb_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 50) begin
        $display("FAIL send_timeout got %0d exp <50", n);
        $fatal(1, "stuck");
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_exp.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 37'(sb_exp.size()), 37'd0);
  endtask

  logic [31:0] vec[12] = '{
    32'h3F800000, 32'hC0000000, 32'h00000000, 32'h80000000,
    32'h7F800000, 32'hFFC00000, 32'h00000001, 32'h00400000,
    32'h807FFFFF, 32'h00800000, 32'h7F7FFFFF, 32'h7F800001
  };

  logic [36:0] held;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_ieee = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 37'(out_valid), 37'd0);
    chk("rst_R", out_R, 37'd0);
    chk("rst_ready", 37'(in_ready), 37'd1);
    @(posedge clk);
    #1;

    // Spot checks of the model against hand-derived words.
    chk("m_one", model(32'h3F800000), 37'h9FF800000);
    chk("m_sub1", model(32'h00000001), 37'h9B5000000);

    // Directed and special values, spaced out.
    foreach (vec[i]) begin
      send(vec[i]);
      @(posedge clk);
      #1;
    end
    drain();

    // Back-to-back stream including random subnormals.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] r;
      r = $urandom;
      if (i % 2 == 1) r[30:23] = 8'd0;
      send(r);
    end
    drain();

    // Backpressure: stall the consumer with the producer active.
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(32'h40000000 + 32'(i));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held = out_R;
        for (int k = 0; k < 5; k++) begin
          chk("stall_ready", 37'(in_ready), 37'd0);
          chk("stall_valid", 37'(out_valid), 37'd1);
          chk("stall_R", out_R, held);
          if (k < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    lat_chk = 1'b1;

    // Reset with both stages full.
    out_ready = 1'b0;
    send(32'h3F800000);
    send(32'hC0000000);
    @(negedge clk);
    chk("full_valid", 37'(out_valid), 37'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    sb_exp.delete();
    sb_cyc.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 37'(out_valid), 37'd0);
    chk("mid_rst_R", out_R, 37'd0);
    @(posedge clk);
    #1;
    send(32'h3F800000);
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
